// File: rtl/trivium_ctrl.sv
// Sequencer for the trivium keystream core: seed intake, load, fixed warm-up,
// generation with timeout, and a registered p/q output held over valid/ready.
package trivium_pkg;
   typedef enum logic [1:0] {
      TRIV_IDLE   = 2'd0,
      TRIV_IV_GEN = 2'd1,
      TRIV_SETUP  = 2'd2,
      TRIV_GEN    = 2'd3
   } trivium_state_t;
endpackage

module trivium_ctrl
   import trivium_pkg::*;
#(
   parameter int KEY_WIDTH    = 80,
   parameter int IV_WIDTH     = 80,
   parameter int SETUP_CYCLES = 1152,
   parameter int GEN_TIMEOUT  = 512
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 abort,
   input  logic                 seed_valid,
   output logic                 seed_ready,
   input  logic [KEY_WIDTH-1:0] seed_key,
   input  logic [IV_WIDTH-1:0]  seed_iv,
   output trivium_state_t       triv_state,
   output logic [KEY_WIDTH-1:0] triv_key,
   output logic [IV_WIDTH-1:0]  triv_iv,
   input  logic                 triv_done,
   input  logic [KEY_WIDTH-1:0] triv_p,
   input  logic [KEY_WIDTH-1:0] triv_q,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [KEY_WIDTH-1:0] out_p,
   output logic [KEY_WIDTH-1:0] out_q,
   output logic                 busy,
   output logic                 err_timeout
);
   localparam int SETUP_W = $clog2(SETUP_CYCLES);
   localparam int GEN_W   = $clog2(GEN_TIMEOUT);
   localparam int CNT_W   = (SETUP_W > GEN_W) ? SETUP_W : GEN_W;
   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] GEN_LAST   = CNT_W'(GEN_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE, S_SEED, S_LOAD, S_SETUP, S_GEN, S_HOLD
   } fsm_t;

   fsm_t                 state_reg, state_next;
   logic [CNT_W-1:0]     cnt_reg, cnt_next;
   trivium_state_t       triv_state_reg, triv_state_next;
   logic [KEY_WIDTH-1:0] key_reg, key_next;
   logic [IV_WIDTH-1:0]  iv_reg, iv_next;
   logic [KEY_WIDTH-1:0] p_reg, p_next;
   logic [KEY_WIDTH-1:0] q_reg, q_next;
   logic                 valid_reg, valid_next;
   logic                 seed_ready_reg, seed_ready_next;
   logic                 busy_reg, busy_next;
   logic                 err_reg, err_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= S_IDLE;
         cnt_reg        <= '0;
         triv_state_reg <= TRIV_IDLE;
         key_reg        <= '0;
         iv_reg         <= '0;
         p_reg          <= '0;
         q_reg          <= '0;
         valid_reg      <= 1'b0;
         seed_ready_reg <= 1'b0;
         busy_reg       <= 1'b0;
         err_reg        <= 1'b0;
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         triv_state_reg <= triv_state_next;
         key_reg        <= key_next;
         iv_reg         <= iv_next;
         p_reg          <= p_next;
         q_reg          <= q_next;
         valid_reg      <= valid_next;
         seed_ready_reg <= seed_ready_next;
         busy_reg       <= busy_next;
         err_reg        <= err_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      cnt_next        = cnt_reg;
      key_next        = key_reg;
      iv_next         = iv_reg;
      p_next          = p_reg;
      q_next          = q_reg;
      valid_next      = valid_reg;
      err_next        = err_reg;
      seed_ready_next = 1'b0;
      busy_next       = 1'b0;
      triv_state_next = TRIV_IDLE;

      case (state_reg)
         S_IDLE: begin
            if (start) begin
               state_next = S_SEED;
               err_next   = 1'b0;
            end
         end
         S_SEED: begin
            if (seed_valid && seed_ready_reg) begin
               key_next   = seed_key;
               iv_next    = seed_iv;
               state_next = S_LOAD;
            end
         end
         S_LOAD: begin
            state_next = S_SETUP;
            cnt_next   = '0;
         end
         S_SETUP: begin
            if (cnt_reg == SETUP_LAST) begin
               state_next = S_GEN;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + CNT_ONE;
            end
         end
         S_GEN: begin
            // done is checked first so a done on the final allowed cycle still captures
            if (triv_done) begin
               p_next     = triv_p;
               q_next     = triv_q;
               valid_next = 1'b1;
               state_next = S_HOLD;
               cnt_next   = '0;
            end else if (cnt_reg == GEN_LAST) begin
               err_next   = 1'b1;
               state_next = S_IDLE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + CNT_ONE;
            end
         end
         S_HOLD: begin
            if (out_ready && valid_reg) begin
               valid_next = 1'b0;
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase

      // abort overrides whatever the state decided, but keeps key/IV and the error flag
      if (abort && (state_reg != S_IDLE)) begin
         state_next = S_IDLE;
         cnt_next   = '0;
         key_next   = key_reg;
         iv_next    = iv_reg;
         p_next     = p_reg;
         q_next     = q_reg;
         valid_next = 1'b0;
         err_next   = err_reg;
      end

      seed_ready_next = (state_next == S_SEED);
      busy_next       = (state_next != S_IDLE);
      case (state_next)
         S_SEED, S_LOAD: triv_state_next = TRIV_IV_GEN;
         S_SETUP:        triv_state_next = TRIV_SETUP;
         S_GEN:          triv_state_next = TRIV_GEN;
         default:        triv_state_next = TRIV_IDLE;
      endcase
   end

   assign seed_ready  = seed_ready_reg;
   assign triv_state  = triv_state_reg;
   assign triv_key    = key_reg;
   assign triv_iv     = iv_reg;
   assign out_valid   = valid_reg;
   assign out_p       = p_reg;
   assign out_q       = q_reg;
   assign busy        = busy_reg;
   assign err_timeout = err_reg;

endmodule

// File: tb/tb_trivium_ctrl.sv
// Bench for trivium_ctrl: a stub core answers GEN after a chosen delay; table and
// random transactions are checked against latency/capture rules, plus reset cases.
module tb_trivium_ctrl;
   import trivium_pkg::*;

   localparam int KW = 80;
   localparam int IW = 80;
   localparam int SC = 1152;
   localparam int GT = 512;
   localparam int NV = 14;

   logic clk = 1'b0, rst_n = 1'b0;
   logic start = 1'b0, abort = 1'b0, seed_valid = 1'b0, out_ready = 1'b0;
   logic seed_ready, out_valid, busy, err_timeout, triv_done;
   logic [KW-1:0] seed_key = '0, triv_key, triv_p, triv_q, out_p, out_q;
   logic [IW-1:0] seed_iv = '0, triv_iv;
   trivium_state_t triv_state;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   trivium_ctrl #(.KEY_WIDTH(KW), .IV_WIDTH(IW), .SETUP_CYCLES(SC), .GEN_TIMEOUT(GT)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .seed_valid(seed_valid), .seed_ready(seed_ready), .seed_key(seed_key), .seed_iv(seed_iv),
      .triv_state(triv_state), .triv_key(triv_key), .triv_iv(triv_iv),
      .triv_done(triv_done), .triv_p(triv_p), .triv_q(triv_q),
      .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .out_q(out_q),
      .busy(busy), .err_timeout(err_timeout)
   );

   // Stub core: counts GEN cycles, raises done when the count reaches done_delay,
   // and emits p/q words that change every GEN cycle.
   int done_delay = -1;
   int gcnt = 0;
   always @(posedge clk) begin
      if (triv_state == TRIV_GEN) gcnt <= gcnt + 1;
      else                        gcnt <= 0;
   end
   assign triv_done = (done_delay >= 0) && (triv_state == TRIV_GEN) && (gcnt == done_delay);
   assign triv_p    = triv_key ^ KW'(triv_iv) ^ KW'(gcnt);
   assign triv_q    = triv_key + KW'(triv_iv) + KW'(gcnt);

   typedef struct {
      logic [KW-1:0] key;
      logic [IW-1:0] iv;
      int            seed_wait;
      int            delay;
      int            ready_wait;
      int            abort_at;
      bit            exp_valid;
      bit            exp_err;
      int            exp_lat;
      logic [KW-1:0] exp_p;
      logic [KW-1:0] exp_q;
   } vec_t;

   vec_t vecs[NV];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [KW-1:0] rnd_word();
      logic [95:0] w;
      w = {$urandom(), $urandom(), $urandom()};
      return w[KW-1:0];
   endfunction

   function automatic vec_t mk(input logic [KW-1:0] key, input logic [IW-1:0] iv,
                               input int sw, input int dly, input int rw, input int ab);
      vec_t v;
      v.key        = key;
      v.iv         = iv;
      v.seed_wait  = sw;
      v.delay      = dly;
      v.ready_wait = rw;
      v.abort_at   = ab;
      v.exp_valid  = (ab < 0) && (dly >= 0) && (dly < GT);
      v.exp_err    = (ab < 0) && !v.exp_valid;
      v.exp_lat    = 1 + SC + dly + 1;
      v.exp_p      = key ^ KW'(iv) ^ KW'(dly);
      v.exp_q      = key + KW'(iv) + KW'(dly);
      return v;
   endfunction

   task automatic run_txn(input int idx);
      vec_t r;
      int lat, n_iv, n_setup, n_gen;
      bit ok, fin;
      logic [KW-1:0] hp, hq;
      r = vecs[idx];
      done_delay = r.delay;

      start = 1'b1; tick(); start = 1'b0;
      check("start_busy", busy, 1);
      check("start_seed_ready", seed_ready, 1);
      check("start_err_clear", err_timeout, 0);
      n_iv = (triv_state == TRIV_IV_GEN) ? 1 : 0;

      ok = 1'b1;
      for (int i = 0; i < r.seed_wait; i++) begin
         seed_key = rnd_word(); seed_iv = rnd_word();
         tick();
         if (triv_state == TRIV_IV_GEN) n_iv++;
         if (!seed_ready || triv_state == TRIV_SETUP) ok = 1'b0;
      end
      if (r.seed_wait > 0) check("seed_stall_hold", ok, 1);

      seed_key = r.key; seed_iv = r.iv; seed_valid = 1'b1;
      tick();
      seed_valid = 1'b0; seed_key = ~r.key; seed_iv = ~r.iv;
      if (triv_state == TRIV_IV_GEN) n_iv++;
      check("seed_ready_drop", seed_ready, 0);
      check("key_latch", triv_key, r.key);
      check("iv_latch", triv_iv, r.iv);

      lat = 0; n_setup = 0; n_gen = 0; fin = 1'b0;
      for (int c = 0; c < 4000 && !fin; c++) begin
         if (r.abort_at >= 0 && n_setup == r.abort_at) begin
            abort = 1'b1; tick(); abort = 1'b0;
            check("abort_triv_idle", triv_state, TRIV_IDLE);
            check("abort_busy", busy, 0);
            check("abort_out_valid", out_valid, 0);
            check("abort_key_kept", triv_key, r.key);
            check("abort_setup_reached", n_setup, r.abort_at);
            fin = 1'b1;
         end else begin
            tick(); lat++;
            if (triv_state == TRIV_SETUP)       n_setup++;
            else if (triv_state == TRIV_GEN)    n_gen++;
            else if (triv_state == TRIV_IV_GEN) n_iv++;
            if (out_valid || !busy) begin
               fin = 1'b1;
               check("out_valid_seen", out_valid, r.exp_valid);
               check("err_timeout", err_timeout, r.exp_err);
               check("iv_gen_cycles", n_iv, r.seed_wait + 2);
               check("setup_cycles", n_setup, SC);
               check("end_triv_idle", triv_state, TRIV_IDLE);
               if (out_valid) begin
                  check("latency", lat, r.exp_lat);
                  check("gen_cycles", n_gen, r.delay + 1);
                  check("out_p", out_p, r.exp_p);
                  check("out_q", out_q, r.exp_q);
                  hp = out_p; hq = out_q; ok = 1'b1;
                  for (int i = 0; i < r.ready_wait; i++) begin
                     start = 1'b1;
                     tick();
                     if (!out_valid || out_p !== hp || out_q !== hq || !busy) ok = 1'b0;
                  end
                  start = 1'b0;
                  if (r.ready_wait > 0) check("backpressure_stable", ok, 1);
                  out_ready = 1'b1; tick(); out_ready = 1'b0;
                  check("handshake_valid_drop", out_valid, 0);
                  check("handshake_idle", busy, 0);
                  out_ready = 1'b1; tick(); out_ready = 1'b0;
                  check("no_queued_start", busy, 0);
                  check("stray_ready", out_valid, 0);
               end else begin
                  check("timeout_gen_cycles", n_gen, GT);
               end
            end
         end
      end
      if (!fin) check("txn_bound", 0, 1);
      $display("[TB] txn %0d delay=%0d seed_wait=%0d ready_wait=%0d abort_at=%0d lat=%0d valid=%0b err=%0b",
               idx, r.delay, r.seed_wait, r.ready_wait, r.abort_at, lat, r.exp_valid, err_timeout);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int ng;
      vecs[0] = mk(80'h01234567890123456789, 80'hFEDCBA98765432FEDC10, 0, 170, 0, -1);
      vecs[1] = mk(80'h01234567890123456789, 80'hFEDCBA98765432FEDC10, 0, 170, 20, -1);
      vecs[2] = mk(rnd_word(), rnd_word(), 50, 5, 1, -1);
      vecs[3] = mk(rnd_word(), rnd_word(), 0, -1, 0, -1);
      vecs[4] = mk(rnd_word(), rnd_word(), 1, 511, 2, -1);
      vecs[5] = mk(rnd_word(), rnd_word(), 0, 512, 0, -1);
      vecs[6] = mk(rnd_word(), rnd_word(), 0, 170, 0, 600);
      vecs[7] = mk(rnd_word(), rnd_word(), 0, 0, 3, -1);
      for (int i = 8; i < NV; i++) begin
         int sw, dly, rw, ab;
         sw  = int'($urandom_range(0, 10));
         dly = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 400));
         rw  = int'($urandom_range(0, 8));
         ab  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, SC - 1)) : -1;
         vecs[i] = mk(rnd_word(), rnd_word(), sw, dly, rw, ab);
      end

      tick(); tick();
      check("reset_triv_state", triv_state, TRIV_IDLE);
      check("reset_busy", busy, 0);
      check("reset_seed_ready", seed_ready, 0);
      check("reset_out_valid", out_valid, 0);
      check("reset_err", err_timeout, 0);
      check("reset_key", triv_key, 0);
      @(negedge clk); rst_n = 1'b1;
      tick();
      check("idle_no_start", busy, 0);

      for (int i = 0; i < NV; i++) run_txn(i);

      // Asynchronous reset in the middle of GEN
      done_delay = 170;
      start = 1'b1; tick(); start = 1'b0;
      seed_key = 80'h01234567890123456789; seed_iv = 80'hFEDCBA98765432FEDC10; seed_valid = 1'b1;
      tick(); seed_valid = 1'b0;
      ng = 0;
      for (int c = 0; c < 2000 && ng < 10; c++) begin
         tick();
         if (triv_state == TRIV_GEN) ng++;
      end
      check("reset_seq_reached_gen", ng, 10);
      #3 rst_n = 1'b0;
      #1;
      check("async_rst_triv_state", triv_state, TRIV_IDLE);
      check("async_rst_busy", busy, 0);
      check("async_rst_key", triv_key, 0);
      check("async_rst_iv", triv_iv, 0);
      check("async_rst_out_p", out_p, 0);
      check("async_rst_out_valid", out_valid, 0);
      @(negedge clk); rst_n = 1'b1;
      tick();
      check("post_rst_idle", busy, 0);
      $display("[TB] async reset at GEN cycle %0d: busy=%0b triv_key=%h", ng, busy, triv_key);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
